// File: rtl/exu_seq_ctrl.sv
// Execute-stage sequencer: routes one decoded op at a time to the shared ALU or to an
// external mul/div unit, then holds the result for writeback under valid/ready backpressure.
module exu_seq_ctrl #(
   parameter int XLEN          = 64,
   parameter int MD_MAX_CYCLES = 80,
   parameter int CNT_W         = 7
) (
   input  logic            clk,
   input  logic            reset,

   input  logic            issue_valid_i,
   output logic            issue_ready_o,
   input  logic            issue_is_md_i,
   input  logic [3:0]      issue_func_i,
   input  logic            issue_word_op_i,
   input  logic [XLEN-1:0] issue_opr_a_i,
   input  logic [XLEN-1:0] issue_opr_b_i,
   input  logic [4:0]      issue_rd_i,

   output logic            alu_valid_o,
   output logic [3:0]      alu_func_o,
   output logic            alu_word_op_o,
   output logic [XLEN-1:0] alu_opr_a_o,
   output logic [XLEN-1:0] alu_opr_b_o,
   input  logic            alu_valid_i,
   input  logic [XLEN-1:0] alu_res_i,

   output logic            md_start_o,
   output logic [3:0]      md_func_o,
   output logic [XLEN-1:0] md_opr_a_o,
   output logic [XLEN-1:0] md_opr_b_o,
   input  logic            md_done_i,
   input  logic [XLEN-1:0] md_res_i,
   output logic            md_kill_o,

   input  logic            flush_i,

   output logic            wb_valid_o,
   input  logic            wb_ready_i,
   output logic [4:0]      wb_rd_o,
   output logic [XLEN-1:0] wb_data_o,

   output logic            md_timeout_o
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] ALU_EXEC = 3'd1;
   localparam logic [2:0] MD_START = 3'd2;
   localparam logic [2:0] MD_WAIT  = 3'd3;
   localparam logic [2:0] RESP     = 3'd4;

   localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(MD_MAX_CYCLES);

   logic [2:0]      state;
   logic [2:0]      state_next;
   logic [3:0]      func;
   logic            word_op;
   logic [XLEN-1:0] opr_a;
   logic [XLEN-1:0] opr_b;
   logic [4:0]      rd;
   logic [XLEN-1:0] result;
   logic [XLEN-1:0] result_next;
   logic            result_load;
   logic [CNT_W-1:0] wd_cnt;
   logic [CNT_W-1:0] wd_cnt_inc;
   logic            wd_fire;
   logic            timeout;
   logic            handshake;
   logic [XLEN-1:0] md_res_ext;

   assign issue_ready_o = ~flush_i & ((state == IDLE) | ((state == RESP) & wb_ready_i));
   assign handshake     = issue_valid_i & issue_ready_o;

   // Counter holds cycles elapsed since md_start_o minus one, so the limit is hit
   // exactly MD_MAX_CYCLES cycles after the start pulse.
   assign wd_cnt_inc = wd_cnt + 1'b1;
   assign md_res_ext = word_op ? {{(XLEN-32){md_res_i[31]}}, md_res_i[31:0]} : md_res_i;

   always_comb begin
      // NOTE: every signal written here gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_next  = state;
      result_load = 1'b0;
      result_next = result;
      wd_fire     = 1'b0;
      case (state)
         IDLE: begin
            if (handshake) state_next = issue_is_md_i ? MD_START : ALU_EXEC;
         end
         ALU_EXEC: begin
            if (alu_valid_i) begin
               result_load = 1'b1;
               result_next = alu_res_i;
               state_next  = RESP;
            end
         end
         MD_START: begin
            state_next = MD_WAIT;
         end
         MD_WAIT: begin
            if (md_done_i) begin
               result_load = 1'b1;
               result_next = md_res_ext;
               state_next  = RESP;
            end else if (wd_cnt_inc == WD_LIMIT) begin
               wd_fire     = 1'b1;
               result_load = 1'b1;
               result_next = '1;
               state_next  = RESP;
            end
         end
         RESP: begin
            if (wb_ready_i) begin
               if (handshake) state_next = issue_is_md_i ? MD_START : ALU_EXEC;
               else           state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      // Flush overrides everything, including a watchdog expiry in the same cycle.
      if (flush_i) begin
         state_next  = IDLE;
         result_load = 1'b0;
         wd_fire     = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         func    <= '0;
         word_op <= 1'b0;
         opr_a   <= '0;
         opr_b   <= '0;
         rd      <= '0;
         result  <= '0;
         wd_cnt  <= '0;
         timeout <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values,
         // independent of statement order.
         state <= state_next;
         if (handshake) begin
            func    <= issue_func_i;
            word_op <= issue_word_op_i;
            opr_a   <= issue_opr_a_i;
            opr_b   <= issue_opr_b_i;
            rd      <= issue_rd_i;
         end
         if (result_load) result <= result_next;
         if (state == MD_START)     wd_cnt <= '0;
         else if (state == MD_WAIT) wd_cnt <= wd_cnt_inc;
         if (wd_fire) timeout <= 1'b1;
      end
   end

   assign alu_valid_o   = (state == ALU_EXEC);
   assign alu_func_o    = func;
   assign alu_word_op_o = word_op;
   assign alu_opr_a_o   = opr_a;
   assign alu_opr_b_o   = opr_b;

   assign md_start_o = (state == MD_START) & ~flush_i;
   assign md_func_o  = func;
   assign md_opr_a_o = opr_a;
   assign md_opr_b_o = opr_b;
   assign md_kill_o  = (flush_i & ((state == MD_START) | (state == MD_WAIT))) | wd_fire;

   // x0 is hardwired to zero, so its writeback data is forced to zero.
   assign wb_valid_o   = (state == RESP);
   assign wb_rd_o      = rd;
   assign wb_data_o    = (rd == 5'd0) ? '0 : result;
   assign md_timeout_o = timeout;

endmodule

// File: tb/tb_exu_seq_ctrl.sv
// Scoreboard bench for exu_seq_ctrl: the driver predicts each op's writeback from a
// behavioural model, a monitor compares every presented writeback, a responder plays mul/div.
module tb_exu_seq_ctrl;

   localparam int XLEN   = 64;
   localparam int MD_MAX = 80;

   typedef struct {
      logic [4:0]  rd;
      logic [63:0] data;
   } exp_t;

   typedef struct {
      int          dly;
      logic [63:0] res;
      logic [3:0]  func;
      logic [63:0] a;
      logic [63:0] b;
   } md_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        issue_valid_i, issue_ready_o, issue_is_md_i, issue_word_op_i;
   logic [3:0]  issue_func_i;
   logic [63:0] issue_opr_a_i, issue_opr_b_i;
   logic [4:0]  issue_rd_i;
   logic        alu_valid_o, alu_word_op_o, alu_valid_i;
   logic [3:0]  alu_func_o;
   logic [63:0] alu_opr_a_o, alu_opr_b_o, alu_res_i;
   logic        md_start_o, md_done_i, md_kill_o;
   logic [3:0]  md_func_o;
   logic [63:0] md_opr_a_o, md_opr_b_o, md_res_i;
   logic        flush_i;
   logic        wb_valid_o, wb_ready_i;
   logic [4:0]  wb_rd_o;
   logic [63:0] wb_data_o;
   logic        md_timeout_o;

   logic        rand_mode   = 1'b0;
   logic        force_ready = 1'b1;
   logic        force_hold  = 1'b0;
   logic        alu_hold;

   exp_t exp_q[$];
   md_t  md_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   hs_cyc = 0;
   int   wb_cyc = 0;

   exu_seq_ctrl #(.XLEN(XLEN), .MD_MAX_CYCLES(MD_MAX), .CNT_W(7)) dut (
      .clk(clk), .reset(reset),
      .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
      .issue_is_md_i(issue_is_md_i), .issue_func_i(issue_func_i),
      .issue_word_op_i(issue_word_op_i), .issue_opr_a_i(issue_opr_a_i),
      .issue_opr_b_i(issue_opr_b_i), .issue_rd_i(issue_rd_i),
      .alu_valid_o(alu_valid_o), .alu_func_o(alu_func_o), .alu_word_op_o(alu_word_op_o),
      .alu_opr_a_o(alu_opr_a_o), .alu_opr_b_o(alu_opr_b_o),
      .alu_valid_i(alu_valid_i), .alu_res_i(alu_res_i),
      .md_start_o(md_start_o), .md_func_o(md_func_o), .md_opr_a_o(md_opr_a_o),
      .md_opr_b_o(md_opr_b_o), .md_done_i(md_done_i), .md_res_i(md_res_i),
      .md_kill_o(md_kill_o), .flush_i(flush_i),
      .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rd_o(wb_rd_o),
      .wb_data_o(wb_data_o), .md_timeout_o(md_timeout_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] alu_fn(input logic [3:0] f, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
      logic [63:0] r;
      case (f)
         4'd0:    r = a + b;
         4'd1:    r = a - b;
         4'd2:    r = a ^ b;
         4'd3:    r = a | b;
         4'd4:    r = a & b;
         default: r = a;
      endcase
      if (w) r = {{32{r[31]}}, r[31:0]};
      return r;
   endfunction

   // Stand-in combinational ALU, optionally stalling its valid.
   assign alu_valid_i = alu_valid_o & ~alu_hold;
   assign alu_res_i   = alu_fn(alu_func_o, alu_word_op_o, alu_opr_a_o, alu_opr_b_o);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Writeback backpressure and ALU stall generator.
   initial begin
      wb_ready_i = 1'b1;
      alu_hold   = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         wb_ready_i = rand_mode ? ($urandom_range(0, 3) != 0) : force_ready;
         alu_hold   = rand_mode ? ($urandom_range(0, 3) == 0) : force_hold;
      end
   end

   // Monitor: every presented writeback must match the oldest outstanding prediction.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset && wb_valid_o) begin
            if (exp_q.size() == 0) begin
               check("wb_spurious_valid", 64'(wb_valid_o), 64'd0);
            end else begin
               check("wb_rd", 64'(wb_rd_o), 64'(exp_q[0].rd));
               check("wb_data", wb_data_o, exp_q[0].data);
               if (wb_ready_i) begin
                  exp_q.delete(0);
                  wb_cyc = cyc;
               end
            end
         end
      end
   end

   // Mul/div responder: answers each start pulse after its planned delay (or never).
   initial begin
      md_t p;
      int  k;
      md_done_i = 1'b0;
      md_res_i  = '0;
      forever begin
         @(negedge clk);
         if (!reset && md_start_o) begin
            if (md_q.size() == 0) begin
               check("md_unexpected_start", 64'(md_start_o), 64'd0);
            end else begin
               p = md_q.pop_front();
               check("md_func", 64'(md_func_o), 64'(p.func));
               check("md_opr_a", md_opr_a_o, p.a);
               check("md_opr_b", md_opr_b_o, p.b);
               @(negedge clk);
               check("md_start_single_pulse", 64'(md_start_o), 64'd0);
               if (p.dly < 0) begin
                  k = 1;
                  while (!md_kill_o && k < 200) begin
                     @(negedge clk);
                     k++;
                  end
                  check("md_watchdog_kill_cycle", 64'(k), 64'(MD_MAX));
               end else begin
                  repeat (p.dly - 1) @(posedge clk);
                  #1;
                  md_done_i = 1'b1;
                  md_res_i  = p.res;
                  @(posedge clk);
                  #1;
                  md_done_i = 1'b0;
                  md_res_i  = '0;
               end
            end
         end
      end
   end

   // Presents one op, waits for acceptance and records the predicted writeback.
   task automatic issue_op(input logic md, input logic [3:0] f, input logic w,
                           input logic [63:0] a, input logic [63:0] b, input logic [4:0] r,
                           input int dly, input logic [63:0] mres);
      logic [63:0] v;
      md_t         p;
      int          n;
      issue_valid_i   = 1'b1;
      issue_is_md_i   = md;
      issue_func_i    = f;
      issue_word_op_i = w;
      issue_opr_a_i   = a;
      issue_opr_b_i   = b;
      issue_rd_i      = r;
      n = 0;
      forever begin
         @(negedge clk);
         if (issue_ready_o) break;
         n++;
         if (n > 400) begin
            checks++;
            errors++;
            $display("FAIL issue_handshake actual=never_ready required=accept");
            issue_valid_i = 1'b0;
            return;
         end
      end
      if (md) begin
         if (dly < 0 || dly > MD_MAX) v = '1;
         else if (w)                  v = {{32{mres[31]}}, mres[31:0]};
         else                         v = mres;
         p.dly = dly; p.res = mres; p.func = f; p.a = a; p.b = b;
         md_q.push_back(p);
      end else begin
         v = alu_fn(f, w, a, b);
      end
      if (r == 5'd0) v = '0;
      exp_q.push_back('{rd: r, data: v});
      hs_cyc = cyc;
      @(posedge clk);
      #1;
      issue_valid_i = 1'b0;
   endtask

   task automatic drain(input int limit);
      int n = 0;
      while (exp_q.size() != 0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain actual=%0d_pending required=0", exp_q.size());
         exp_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL global_time_limit actual=expired required=finish");
      $fatal(1, "simulation time limit");
   end

   initial begin
      reset = 1'b1;
      issue_valid_i = 1'b0; issue_is_md_i = 1'b0; issue_func_i = '0; issue_word_op_i = 1'b0;
      issue_opr_a_i = '0; issue_opr_b_i = '0; issue_rd_i = '0; flush_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_issue_ready", 64'(issue_ready_o), 64'd1);
      check("rst_wb_valid", 64'(wb_valid_o), 64'd0);
      check("rst_md_start", 64'(md_start_o), 64'd0);
      check("rst_md_kill", 64'(md_kill_o), 64'd0);
      check("rst_md_timeout", 64'(md_timeout_o), 64'd0);
      check("rst_alu_valid", 64'(alu_valid_o), 64'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Single ALU ADD with exact latency.
      issue_op(1'b0, 4'd0, 1'b0, 64'd5, 64'd7, 5'd3, 0, '0);
      @(negedge clk);
      check("t1_alu_valid_n1", 64'(alu_valid_o), 64'd1);
      check("t1_alu_opr_a", alu_opr_a_o, 64'd5);
      check("t1_alu_opr_b", alu_opr_b_o, 64'd7);
      @(negedge clk);
      check("t1_wb_valid_n2", 64'(wb_valid_o), 64'd1);
      check("t1_wb_data", wb_data_o, 64'd12);
      @(negedge clk);
      check("t1_idle_wb_valid", 64'(wb_valid_o), 64'd0);
      check("t1_idle_ready", 64'(issue_ready_o), 64'd1);
      @(posedge clk);
      #1;

      // Back-to-back ALU ops with three cycles of writeback stall on the first.
      force_ready = 1'b0;
      issue_op(1'b0, 4'd0, 1'b0, 64'd20, 64'd22, 5'd7, 0, '0);
      fork
         issue_op(1'b0, 4'd2, 1'b0, 64'hF0F0, 64'h0FF0, 5'd8, 0, '0);
         begin
            int n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (!wb_valid_o && n < 20);
            for (int i = 0; i < 3; i++) begin
               if (i > 0) @(negedge clk);
               check("t2_stall_issue_ready", 64'(issue_ready_o), 64'd0);
               check("t2_stall_wb_data", wb_data_o, 64'd42);
            end
            @(posedge clk);
            #1;
            force_ready = 1'b1;
         end
      join
      check("t2_accept_on_wb_cycle", 64'(hs_cyc), 64'(wb_cyc));
      @(negedge clk);
      check("t2_second_alu_valid", 64'(alu_valid_o), 64'd1);
      @(negedge clk);
      check("t2_second_wb_valid", 64'(wb_valid_o), 64'd1);
      drain(50);

      // Word mul/div result sign-extended.
      issue_op(1'b1, 4'd1, 1'b1, 64'd3, 64'd9, 5'd5, 10, 64'h0000_0000_8000_0000);
      drain(100);

      // Flush in the fourth MD_WAIT cycle; the late done must be ignored.
      issue_op(1'b1, 4'd2, 1'b0, 64'd11, 64'd13, 5'd6, 6, 64'h1234);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      flush_i = 1'b1;
      @(negedge clk);
      check("t4_flush_kill", 64'(md_kill_o), 64'd1);
      check("t4_flush_no_accept", 64'(issue_ready_o), 64'd0);
      exp_q.delete(exp_q.size() - 1);
      @(posedge clk);
      #1;
      flush_i = 1'b0;
      repeat (6) begin
        @(negedge clk);
        check("t4_no_wb_after_flush", 64'(wb_valid_o), 64'd0);
      end
      @(posedge clk);
      #1;
      issue_op(1'b0, 4'd1, 1'b0, 64'd100, 64'd1, 5'd12, 0, '0);
      drain(50);

      // Done on the very cycle of the watchdog limit: done wins.
      issue_op(1'b1, 4'd3, 1'b0, 64'd1, 64'd2, 5'd9, MD_MAX, 64'hDEAD_BEEF_0BAD_F00D);
      drain(200);
      check("t5_no_timeout_at_limit", 64'(md_timeout_o), 64'd0);

      // Done never arrives: watchdog kill, all-ones result, sticky flag.
      issue_op(1'b1, 4'd0, 1'b0, 64'd4, 64'd4, 5'd10, -1, '0);
      drain(200);
      check("t5_timeout_flag", 64'(md_timeout_o), 64'd1);

      // rd=0 forces zero data; then reset in the middle of ALU_EXEC.
      issue_op(1'b0, 4'd0, 1'b0, 64'd1, 64'd1, 5'd0, 0, '0);
      drain(50);
      check("t6_timeout_still_sticky", 64'(md_timeout_o), 64'd1);
      force_hold = 1'b1;
      issue_op(1'b0, 4'd0, 1'b0, 64'd3, 64'd4, 5'd11, 0, '0);
      @(negedge clk);
      check("t6_in_alu_exec", 64'(alu_valid_o), 64'd1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("t6_rst_alu_valid", 64'(alu_valid_o), 64'd0);
      check("t6_rst_wb_valid", 64'(wb_valid_o), 64'd0);
      check("t6_rst_md_kill", 64'(md_kill_o), 64'd0);
      check("t6_rst_md_timeout", 64'(md_timeout_o), 64'd0);
      check("t6_rst_issue_ready", 64'(issue_ready_o), 64'd1);
      exp_q.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      force_hold = 1'b0;

      // Randomized mix with random backpressure and ALU stalls.
      rand_mode = 1'b1;
      for (int i = 0; i < 60; i++) begin
         logic md;
         md = ($urandom_range(0, 2) == 0);
         issue_op(md, 4'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom_range(0, 31)),
                  int'($urandom_range(2, 30)), {$urandom, $urandom});
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      rand_mode   = 1'b0;
      force_ready = 1'b1;
      force_hold  = 1'b0;
      drain(500);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/exu_seq_ctrl.md
Name: exu_seq_ctrl

Overview:
- Execute-stage sequencer. Accepts one decoded op at a time from issue.
- Routes single-cycle ops to the shared combinational ALU and multi-cycle ops to an external mul/div unit through a start/done handshake.
- Buffers the result and presents it to writeback with valid/ready backpressure.
- Handles pipeline flush, kills an in-flight mul/div and runs a watchdog on mul/div latency.

Parameters:
- XLEN, 64, operand/result width
- MD_MAX_CYCLES, 80, max cycles from md_start_o to md_done_i before watchdog fires
- CNT_W, 7, width of the watchdog counter; must satisfy 2^CNT_W > MD_MAX_CYCLES

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- issue_valid_i  in  1  issue has an op
- issue_ready_o  out  1  controller accepts op this cycle
- issue_is_md_i  in  1  1 = mul/div op, 0 = ALU op
- issue_func_i  in  4  ALU func code (cpu_consts OP_*) or mul/div func
- issue_word_op_i  in  1  32-bit op, result sign-extended
- issue_opr_a_i / issue_opr_b_i  in  XLEN  operands
- issue_rd_i  in  5  destination register
- alu_valid_o  out  1  drive ALU this cycle
- alu_func_o  out  4  ALU func
- alu_word_op_o  out  1  ALU word op
- alu_opr_a_o / alu_opr_b_o  out  XLEN  ALU operands
- alu_valid_i  in  1  ALU result valid
- alu_res_i  in  XLEN  ALU result
- md_start_o  out  1  one-cycle start pulse to mul/div
- md_func_o  out  4  mul/div func
- md_opr_a_o / md_opr_b_o  out  XLEN  mul/div operands
- md_done_i  in  1  mul/div result valid, one-cycle pulse
- md_res_i  in  XLEN  mul/div raw result
- md_kill_o  out  1  abort in-flight mul/div
- flush_i  in  1  pipeline flush
- wb_valid_o  out  1  result available
- wb_ready_i  in  1  writeback accepts
- wb_rd_o  out  5  destination register
- wb_data_o  out  XLEN  result
- md_timeout_o  out  1  sticky watchdog flag

Behaviour:
- States: IDLE, ALU_EXEC, MD_START, MD_WAIT, RESP. Reset → IDLE.
- Reset values: all registers 0; wb_valid_o=0, md_start_o=0, md_kill_o=0, md_timeout_o=0, issue_ready_o=1.
- Accept:
  - issue_ready_o = ~flush_i & (IDLE | (RESP & wb_ready_i)).
  - Handshake = issue_valid_i & issue_ready_o. On handshake, latch func, word_op, opr_a, opr_b, rd, is_md.
  - Next state is MD_START if is_md, else ALU_EXEC.
  - RESP with wb_ready_i and a new handshake goes directly to the next exec state (back-to-back, no bubble).
- ALU_EXEC:
  - alu_valid_o=1; alu_* outputs driven from the latched registers. alu_* outputs are held stable in all states.
  - If alu_valid_i, latch alu_res_i into the result register and go to RESP. Otherwise stay in ALU_EXEC.
  - Latency: handshake in cycle N, ALU in N+1, wb_valid_o in N+2.
- MD_START:
  - md_start_o=1 for exactly one cycle; watchdog counter cleared; go to MD_WAIT.
- MD_WAIT:
  - Counter increments each cycle.
  - On md_done_i: result = word_op ? sign-extend(md_res_i[31:0]) : md_res_i; go to RESP.
  - If counter reaches MD_MAX_CYCLES without md_done_i:
    - md_kill_o=1 for that cycle and md_timeout_o set (sticky until reset).
    - Result register = all-ones; go to RESP.
  - md_done_i in the same cycle as the limit: done wins, no timeout.
- RESP:
  - wb_valid_o=1; wb_rd_o/wb_data_o stable until wb_ready_i.
  - rd==0: wb_data_o forced 0, valid still asserted.
  - On wb_ready_i without a new handshake → IDLE.
- Flush (any state, highest priority):
  - Next state IDLE; wb_valid_o and alu_valid_o deasserted next cycle.
  - Issue not accepted in the flush cycle.
  - md_kill_o=1 combinationally if state is MD_START or MD_WAIT. md_start_o is suppressed if flush coincides with MD_START.
  - A late md_done_i in IDLE is ignored.
  - alu_valid_o is still 1 combinationally in an ALU_EXEC flush cycle; the ALU masks it via its own flush input, and the result is discarded.
- md_func_o/md_opr_* driven from the latched registers.
- Reset asserted mid-operation: immediate return to IDLE with reset values; md_kill_o is not asserted (mul/div shares reset).

Test Plan:
- ALU ADD, a=5, b=7, rd=3, wb_ready_i=1 → alu_valid_o in N+1, wb_valid_o in N+2 with wb_rd_o=3, wb_data_o=12, then IDLE.
- Two back-to-back ALU ops, wb_ready_i=0 for 3 cycles on the first → wb_data_o held, issue_ready_o=0; second op accepted in the cycle wb_ready_i rises; no bubble.
- MD op, word_op=1, md_done_i 10 cycles after md_start_o with md_res_i=64'h0000_0000_8000_0000 → one md_start_o pulse, wb_data_o=64'hFFFF_FFFF_8000_0000.
- MD op, flush_i in cycle 4 of MD_WAIT → md_kill_o=1 that cycle, no wb_valid_o; md_done_i 2 cycles later is ignored; next issue accepted normally.
- MD op, md_done_i never arrives → at MD_MAX_CYCLES=80: md_kill_o pulse, md_timeout_o=1 and sticky, wb_data_o=all-ones.
- ALU op with rd=0, a=1, b=1 → wb_valid_o=1, wb_data_o=0; reset asserted in ALU_EXEC → immediate IDLE, all outputs at reset values.
